layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Control FSM that sequences the NeuralAccelerator multiply-accumulate datapath through a multi-layer fully connected network. It walks layers, neurons and input terms, and issues per-cycle operand addresses and accumulator control to the shared MAC/activation pipeline. It also issues writebacks of neuron outputs into the activation memory. On completion it publishes the location and size of the final layer's output as `result_base_address` and `result_word_count`.

## Interface
- `ADDR_W`, 8: width of all memory addresses and counters.
- `LAYER_W`, 2: width of layer index; up to 2^LAYER_W layers.
- `PIPE_LAT`, 2: cycles from the last `rd_en` of a neuron until the activated result is valid at the datapath output.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_layers`  in  LAYER_W+1  number of layers to run (0 allowed).
- `input_base`  in  ADDR_W  address of layer-0 input vector.
- `input_count`  in  ADDR_W  word count of layer-0 input vector.
- `weight_base`  in  ADDR_W  address of first weight; weights are packed sequentially across all neurons and layers.
- `cfg_layer`  out  LAYER_W  layer index whose neuron count is requested.
- `cfg_neurons`  in  ADDR_W  neuron count of layer `cfg_layer`; combinational lookup.
- `stall`  in  1  datapath back-pressure; freezes the FSM and counters.
- `rd_en`  out  1  operand read strobe.
- `data_addr`  out  ADDR_W  activation operand address.
- `weight_addr`  out  ADDR_W  weight operand address.
- `acc_first`  out  1  clear accumulator and load this term.
- `acc_last`  out  1  final term of the neuron.
- `wr_en`  out  1  writeback strobe for the activated neuron output.
- `wr_addr`  out  ADDR_W  writeback address.
- `busy`  out  1  high from LOAD through DONE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; set on a zero-sized layer, cleared by the next accepted `start` or by reset.
- `result_base_address`  out  ADDR_W  base address of the final output vector.
- `result_word_count`  out  ADDR_W  word count of the final output vector.

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, WRITE, DONE.
- IDLE, `start`=1:
  - Latch `in_base=input_base`, `in_cnt=input_count`, `wptr=weight_base`, `layer=0`; clear `error`.
  - If `num_layers`=0, go to DONE with `result_base_address=input_base` and `result_word_count=input_count`.
  - Otherwise go to LOAD.
- LOAD:
  - Drive `cfg_layer=layer`; latch `n_cnt=cfg_neurons`; set `out_base=in_base+in_cnt`, `n=0`, `i=0`.
  - If `n_cnt`=0 or `in_cnt`=0, set `error` and go to DONE; the result registers are not updated.
  - Otherwise go to ISSUE.
- ISSUE, one term per cycle:
  - Outputs: `rd_en=1`, `data_addr=in_base+i`, `weight_addr=wptr`, `acc_first=(i==0)`, `acc_last=(i==in_cnt-1)`.
  - Each cycle: `wptr++`, `i++`. After the last term, `i=0` and go to DRAIN.
- DRAIN: wait exactly `PIPE_LAT` cycles, then go to WRITE. `PIPE_LAT`=0 goes directly to WRITE.
- WRITE (one cycle): `wr_en=1`, `wr_addr=out_base+n`; then `n++`.
  - More neurons remain: go to ISSUE.
  - Last neuron, more layers remain: set `in_base=out_base`, `in_cnt=n_cnt`, `layer++`; go to LOAD.
  - Last neuron of last layer: set `result_base_address=out_base`, `result_word_count=n_cnt`; go to DONE.
- DONE (one cycle): `done=1`; then go to IDLE.
- All address arithmetic is modulo 2^ADDR_W and wraps silently; no overflow detection.
- `start` outside IDLE is ignored.
- `stall`=1:
  - Holds state, counters and all registered outputs.
  - Forces `rd_en`, `wr_en` and `done` low for that cycle.
  - `acc_first` and `acc_last` hold their values and are re-qualified on the resumed `rd_en`.
- Reset mid-run:
  - Aborts immediately with no writeback.
  - All outputs go to 0 on the next edge, including the result registers and `error`.

## Timing
- Every output is 0 after reset.
- `start` is sampled at edge T0; LOAD occupies cycle T0+1.
- Cycles per neuron: `in_cnt + PIPE_LAT + 1`. Each layer adds 1 LOAD cycle; DONE is the final cycle.
- `busy` is registered, high for LOAD through DONE inclusive.
- `result_*` update on the same edge that enters DONE, so they are valid together with `done`, and are held until the next accepted `start` completes.
- Each `stall` cycle delays every subsequent event by exactly one cycle.

## Configuration
- `SEQ_BIAS_EN` defined:
  - Each neuron gets one extra ISSUE cycle after its input terms.
  - That cycle has `rd_en=1`, `data_addr=0`, `weight_addr=wptr` (the bias word) and `acc_last=1`; the preceding input term has `acc_last=0`.
  - `wptr` advances by `in_cnt+1` per neuron; cycles per neuron become `in_cnt + PIPE_LAT + 2`.
- Undefined: no bias term is issued, as described above.

## Test plan
- Single layer, `PIPE_LAT`=2, `input_base`=0x10, `input_count`=3, `weight_base`=0x80, neurons=2, start at T0:
  - Reads (0x10/0x80..0x12/0x82) then (0x10/0x83..0x12/0x85).
  - Writes 0x13 at T0+7 and 0x14 at T0+13; `done` at T0+14; result=0x13/2.
- Two layers, [2,1], otherwise as above: layer 1 reads 0x13..0x14 with weights 0x86..0x87, writes 0x15; result=0x15/1.
- `num_layers`=0: `done` at T0+1, result=`input_base`/`input_count`, no `rd_en` or `wr_en`.
- `cfg_neurons`=0 on layer 0: `error`=1, `done` pulses, no `rd_en`; result keeps its previous value.
- Wrap and stall: `input_base`=0xFE, `input_count`=3 gives data addresses 0xFE, 0xFF, 0x00. 2 stall cycles mid-ISSUE shift `done` by exactly 2 cycles with no duplicated or dropped `rd_en`.
- Reset asserted during DRAIN: no `wr_en` issued, all outputs 0; a subsequent `start` runs normally. Also: `start` pulses while busy are ignored.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Datapath-facing bus of the layer sequencer: operand read strobe and
// addresses, accumulator control, neuron writeback, and the datapath's
// back-pressure. The sequencer drives it as master; the MAC/activation
// pipeline sits on the slave side.
interface layer_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] weight_addr;
    logic              acc_first;
    logic              acc_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        input  stall,
        output rd_en, data_addr, weight_addr, acc_first, acc_last, wr_en, wr_addr
    );

    modport slave (
        output stall,
        input  rd_en, data_addr, weight_addr, acc_first, acc_last, wr_en, wr_addr
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer for the NeuralAccelerator MAC/activation pipeline.
// Walks layers, neurons and input terms of a fully connected network, issuing
// one operand read per cycle, waiting out the pipeline latency, then writing
// each activated neuron output back to activation memory. Each layer's output
// vector is placed directly after its input vector, and the final one is
// published on result_base_address_o / result_word_count_o.
// Optional feature: define SEQ_BIAS_EN to append a bias term (data address 0,
// weight from the packed weight stream) after the input terms of every neuron.
module layer_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int LAYER_W  = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [LAYER_W:0]   num_layers_i,
    input  logic [ADDR_W-1:0]  input_base_i,
    input  logic [ADDR_W-1:0]  input_count_i,
    input  logic [ADDR_W-1:0]  weight_base_i,
    output logic [LAYER_W-1:0] cfg_layer_o,
    input  logic [ADDR_W-1:0]  cfg_neurons_i,
    layer_sequencer_if.master  bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [ADDR_W-1:0]  result_base_address_o,
    output logic [ADDR_W-1:0]  result_word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t             state_q;
    logic [ADDR_W-1:0]  in_base_q;
    logic [ADDR_W-1:0]  in_cnt_q;
    logic [ADDR_W-1:0]  wptr_q;
    logic [LAYER_W-1:0] layer_q;
    logic [LAYER_W:0]   nl_q;
    logic [ADDR_W-1:0]  n_cnt_q;
    logic [ADDR_W-1:0]  out_base_q;
    logic [ADDR_W-1:0]  n_q;
    logic [ADDR_W-1:0]  i_q;
    logic [DRAIN_W-1:0] drain_q;

    logic               rd_en_q;
    logic [ADDR_W-1:0]  data_addr_q;
    logic [ADDR_W-1:0]  weight_addr_q;
    logic               acc_first_q;
    logic               acc_last_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [ADDR_W-1:0]  res_base_q;
    logic [ADDR_W-1:0]  res_cnt_q;

    logic [ADDR_W-1:0]  i_d;
    logic [ADDR_W-1:0]  wptr_d;
    logic [ADDR_W-1:0]  n_d;
    logic [LAYER_W:0]   layer_d;
    logic [ADDR_W-1:0]  last_idx;
    logic               i_d_bias;
    logic               first_is_last;

    assign i_d     = i_q + ADDR_W'(1);
    assign wptr_d  = wptr_q + ADDR_W'(1);
    assign n_d     = n_q + ADDR_W'(1);
    assign layer_d = {1'b0, layer_q} + (LAYER_W + 1)'(1);

    // Index of the final term of a neuron, and whether the next term is the bias word.
`ifdef SEQ_BIAS_EN
    assign last_idx = in_cnt_q;
    assign i_d_bias = (i_d == in_cnt_q);
`else
    assign last_idx = in_cnt_q - ADDR_W'(1);
    assign i_d_bias = 1'b0;
`endif

    // A single-input neuron without bias has term 0 as its last term.
    assign first_is_last = (last_idx == '0);

    // Sequencer FSM: all state, counters and outputs advance together and freeze on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_base_q     <= '0;
            in_cnt_q      <= '0;
            wptr_q        <= '0;
            layer_q       <= '0;
            nl_q          <= '0;
            n_cnt_q       <= '0;
            out_base_q    <= '0;
            n_q           <= '0;
            i_q           <= '0;
            drain_q       <= '0;
            rd_en_q       <= 1'b0;
            data_addr_q   <= '0;
            weight_addr_q <= '0;
            acc_first_q   <= 1'b0;
            acc_last_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            res_base_q    <= '0;
            res_cnt_q     <= '0;
        end else if (!bus.stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        in_base_q <= input_base_i;
                        in_cnt_q  <= input_count_i;
                        wptr_q    <= weight_base_i;
                        layer_q   <= '0;
                        nl_q      <= num_layers_i;
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (num_layers_i == '0) begin
                            res_base_q <= input_base_i;
                            res_cnt_q  <= input_count_i;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    n_cnt_q    <= cfg_neurons_i;
                    out_base_q <= in_base_q + in_cnt_q;
                    n_q        <= '0;
                    i_q        <= '0;
                    if (cfg_neurons_i == '0 || in_cnt_q == '0) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rd_en_q       <= 1'b1;
                        data_addr_q   <= in_base_q;
                        weight_addr_q <= wptr_q;
                        acc_first_q   <= 1'b1;
                        acc_last_q    <= first_is_last;
                        state_q       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wptr_q <= wptr_d;
                    if (i_q == last_idx) begin
                        i_q         <= '0;
                        rd_en_q     <= 1'b0;
                        acc_first_q <= 1'b0;
                        acc_last_q  <= 1'b0;
                        if (PIPE_LAT == 0) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= out_base_q + n_q;
                            state_q   <= S_WRITE;
                        end else begin
                            drain_q <= DRAIN_INIT;
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        i_q           <= i_d;
                        data_addr_q   <= i_d_bias ? '0 : in_base_q + i_d;
                        weight_addr_q <= wptr_d;
                        acc_first_q   <= 1'b0;
                        acc_last_q    <= (i_d == last_idx);
                    end
                end

                S_DRAIN: begin
                    if (drain_q == '0) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= out_base_q + n_q;
                        state_q   <= S_WRITE;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end

                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    n_q     <= n_d;
                    if (n_d != n_cnt_q) begin
                        rd_en_q       <= 1'b1;
                        data_addr_q   <= in_base_q;
                        weight_addr_q <= wptr_q;
                        acc_first_q   <= 1'b1;
                        acc_last_q    <= first_is_last;
                        state_q       <= S_ISSUE;
                    end else if (layer_d == nl_q) begin
                        res_base_q <= out_base_q;
                        res_cnt_q  <= n_cnt_q;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        in_base_q <= out_base_q;
                        in_cnt_q  <= n_cnt_q;
                        layer_q   <= layer_q + LAYER_W'(1);
                        state_q   <= S_LOAD;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes are suppressed during a stall cycle so each term and writeback is seen once.
    assign bus.rd_en       = rd_en_q & ~bus.stall;
    assign bus.wr_en       = wr_en_q & ~bus.stall;
    assign done_o          = done_q & ~bus.stall;
    assign bus.data_addr   = data_addr_q;
    assign bus.weight_addr = weight_addr_q;
    assign bus.acc_first   = acc_first_q;
    assign bus.acc_last    = acc_last_q;
    assign bus.wr_addr     = wr_addr_q;
    assign cfg_layer_o     = layer_q;
    assign busy_o          = busy_q;
    assign error_o         = error_q;
    assign result_base_address_o = res_base_q;
    assign result_word_count_o   = res_cnt_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (default build, PIPE_LAT=2).
// A negedge monitor logs every read, writeback and done pulse with its cycle
// number; each scenario then compares the log against hand-computed events,
// where cycle k means the k-th cycle after the edge that samples start.
module tb_layer_sequencer;
    localparam int ADDR_W   = 8;
    localparam int LAYER_W  = 2;
    localparam int PIPE_LAT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [LAYER_W:0]   num_layers = '0;
    logic [ADDR_W-1:0]  input_base = '0;
    logic [ADDR_W-1:0]  input_count = '0;
    logic [ADDR_W-1:0]  weight_base = '0;
    logic [LAYER_W-1:0] cfg_layer;
    logic [ADDR_W-1:0]  cfg_neurons;
    logic               busy, done, error;
    logic [ADDR_W-1:0]  res_base, res_cnt;
    logic [ADDR_W-1:0]  neur_tab [4];

    layer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    layer_sequencer #(
        .ADDR_W(ADDR_W), .LAYER_W(LAYER_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_i               (start),
        .num_layers_i          (num_layers),
        .input_base_i          (input_base),
        .input_count_i         (input_count),
        .weight_base_i         (weight_base),
        .cfg_layer_o           (cfg_layer),
        .cfg_neurons_i         (cfg_neurons),
        .bus                   (bus),
        .busy_o                (busy),
        .done_o                (done),
        .error_o               (error),
        .result_base_address_o (res_base),
        .result_word_count_o   (res_cnt)
    );

    always #5 clk = ~clk;

    always_comb cfg_neurons = neur_tab[cfg_layer];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  da;
        logic [7:0]  wa;
        logic        af;
        logic        al;
    } rd_ev_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  a;
    } wr_ev_t;

    rd_ev_t      rd_q[$];
    wr_ev_t      wr_q[$];
    int unsigned done_q[$];

    int tbase = 0;
    int n_checks = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (bus.rd_en) rd_q.push_back({cyc, bus.data_addr, bus.weight_addr, bus.acc_first, bus.acc_last});
        if (bus.wr_en) wr_q.push_back({cyc, bus.wr_addr});
        if (done)      done_q.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [LAYER_W:0] nl, input logic [7:0] ib, input logic [7:0] ic,
                          input logic [7:0] wb);
        num_layers  = nl;
        input_base  = ib;
        input_count = ic;
        weight_base = wb;
        start = 1'b1;
        step();
        start = 1'b0;
        tbase = int'(cyc) - 1;
    endtask

    task automatic run_to(input int k);
        for (int g = 0; g < 200 && (int'(cyc) - tbase) < k; g++) step();
    endtask

    task automatic exp_rd(input string tag, input int k, input logic [7:0] da, input logic [7:0] wa,
                          input logic af, input logic al);
        rd_ev_t e;
        chk({tag, "-present"}, 64'(rd_q.size() != 0), 64'(1));
        if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            chk(tag, 64'({32'(int'(e.cyc) - tbase), e.da, e.wa, e.af, e.al}),
                64'({32'(k), da, wa, af, al}));
        end
    endtask

    task automatic exp_wr(input string tag, input int k, input logic [7:0] a);
        wr_ev_t e;
        chk({tag, "-present"}, 64'(wr_q.size() != 0), 64'(1));
        if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            chk(tag, 64'({32'(int'(e.cyc) - tbase), e.a}), 64'({32'(k), a}));
        end
    endtask

    task automatic exp_done(input string tag, input int k);
        int unsigned c;
        chk({tag, "-present"}, 64'(done_q.size() != 0), 64'(1));
        if (done_q.size() != 0) begin
            c = done_q.pop_front();
            chk(tag, 64'(32'(int'(c) - tbase)), 64'(32'(k)));
        end
    endtask

    task automatic exp_empty(input string tag);
        chk({tag, "-extra-events"}, 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'(0));
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic chk_result(input string tag, input logic [7:0] b, input logic [7:0] c);
        chk(tag, 64'({res_base, res_cnt}), 64'({b, c}));
    endtask

    initial begin
        bus.stall = 1'b0;
        neur_tab[0] = 8'd2;
        neur_tab[1] = 8'd1;
        neur_tab[2] = 8'd0;
        neur_tab[3] = 8'd0;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("reset-ctrl", 64'({bus.rd_en, bus.wr_en, busy, done, error, bus.acc_first, bus.acc_last, cfg_layer}), 64'(0));
        chk("reset-addr", 64'({bus.data_addr, bus.weight_addr, bus.wr_addr, res_base, res_cnt}), 64'(0));
        reset = 1'b0;
        step();
        exp_empty("reset");

        // Single layer, 2 neurons of 3 inputs
        launch(3'd1, 8'h10, 8'd3, 8'h80);
        chk("t1-busy-load", 64'(busy), 64'(1));
        run_to(16);
        exp_rd("t1-rd0", 2,  8'h10, 8'h80, 1'b1, 1'b0);
        exp_rd("t1-rd1", 3,  8'h11, 8'h81, 1'b0, 1'b0);
        exp_rd("t1-rd2", 4,  8'h12, 8'h82, 1'b0, 1'b1);
        exp_rd("t1-rd3", 8,  8'h10, 8'h83, 1'b1, 1'b0);
        exp_rd("t1-rd4", 9,  8'h11, 8'h84, 1'b0, 1'b0);
        exp_rd("t1-rd5", 10, 8'h12, 8'h85, 1'b0, 1'b1);
        exp_wr("t1-wr0", 7,  8'h13);
        exp_wr("t1-wr1", 13, 8'h14);
        exp_done("t1-done", 14);
        exp_empty("t1");
        chk_result("t1-result", 8'h13, 8'd2);
        chk("t1-busy-idle", 64'(busy), 64'(0));

        // Two layers [2,1]
        launch(3'd2, 8'h10, 8'd3, 8'h80);
        run_to(14);
        chk("t2-cfg-layer", 64'(cfg_layer), 64'(1));
        run_to(22);
        exp_rd("t2-rd0", 2,  8'h10, 8'h80, 1'b1, 1'b0);
        exp_rd("t2-rd1", 3,  8'h11, 8'h81, 1'b0, 1'b0);
        exp_rd("t2-rd2", 4,  8'h12, 8'h82, 1'b0, 1'b1);
        exp_rd("t2-rd3", 8,  8'h10, 8'h83, 1'b1, 1'b0);
        exp_rd("t2-rd4", 9,  8'h11, 8'h84, 1'b0, 1'b0);
        exp_rd("t2-rd5", 10, 8'h12, 8'h85, 1'b0, 1'b1);
        exp_rd("t2-rd6", 15, 8'h13, 8'h86, 1'b1, 1'b0);
        exp_rd("t2-rd7", 16, 8'h14, 8'h87, 1'b0, 1'b1);
        exp_wr("t2-wr0", 7,  8'h13);
        exp_wr("t2-wr1", 13, 8'h14);
        exp_wr("t2-wr2", 19, 8'h15);
        exp_done("t2-done", 20);
        exp_empty("t2");
        chk_result("t2-result", 8'h15, 8'd1);

        // Zero layers: straight to DONE with the input vector as result
        launch(3'd0, 8'h40, 8'd5, 8'h90);
        chk("t3-busy-done", 64'({busy, done}), 64'(2'b11));
        run_to(4);
        exp_done("t3-done", 1);
        exp_empty("t3");
        chk_result("t3-result", 8'h40, 8'd5);

        // Zero-neuron layer: error, done, result untouched
        neur_tab[0] = 8'd0;
        launch(3'd1, 8'h20, 8'd4, 8'h80);
        run_to(5);
        exp_done("t4-done", 2);
        exp_empty("t4");
        chk("t4-error", 64'(error), 64'(1));
        chk_result("t4-result-kept", 8'h40, 8'd5);

        // Address wrap with two stall cycles mid-ISSUE
        neur_tab[0] = 8'd1;
        launch(3'd1, 8'hFE, 8'd3, 8'h80);
        chk("t5-error-cleared", 64'(error), 64'(0));
        run_to(3);
        bus.stall = 1'b1;
        #1;
        chk("t5-stall-rd", 64'(bus.rd_en), 64'(0));
        step();
        step();
        bus.stall = 1'b0;
        run_to(12);
        exp_rd("t5-rd0", 2, 8'hFE, 8'h80, 1'b1, 1'b0);
        exp_rd("t5-rd1", 5, 8'hFF, 8'h81, 1'b0, 1'b0);
        exp_rd("t5-rd2", 6, 8'h00, 8'h82, 1'b0, 1'b1);
        exp_wr("t5-wr0", 9, 8'h01);
        exp_done("t5-done", 10);
        exp_empty("t5");
        chk_result("t5-result", 8'h01, 8'd1);

        // Reset during DRAIN aborts without writeback
        neur_tab[0] = 8'd2;
        launch(3'd1, 8'h10, 8'd3, 8'h80);
        run_to(5);
        reset = 1'b1;
        step();
        chk("t6-rst-ctrl", 64'({bus.rd_en, bus.wr_en, busy, done, error, bus.acc_first, bus.acc_last, cfg_layer}), 64'(0));
        chk("t6-rst-addr", 64'({bus.data_addr, bus.weight_addr, bus.wr_addr, res_base, res_cnt}), 64'(0));
        reset = 1'b0;
        step();
        exp_rd("t6-rd0", 2, 8'h10, 8'h80, 1'b1, 1'b0);
        exp_rd("t6-rd1", 3, 8'h11, 8'h81, 1'b0, 1'b0);
        exp_rd("t6-rd2", 4, 8'h12, 8'h82, 1'b0, 1'b1);
        exp_empty("t6-abort");

        // Normal run afterwards, with a start pulse while busy that must be ignored
        launch(3'd1, 8'h10, 8'd3, 8'h80);
        run_to(3);
        num_layers = 3'd0;
        input_base = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(16);
        exp_rd("t7-rd0", 2,  8'h10, 8'h80, 1'b1, 1'b0);
        exp_rd("t7-rd1", 3,  8'h11, 8'h81, 1'b0, 1'b0);
        exp_rd("t7-rd2", 4,  8'h12, 8'h82, 1'b0, 1'b1);
        exp_rd("t7-rd3", 8,  8'h10, 8'h83, 1'b1, 1'b0);
        exp_rd("t7-rd4", 9,  8'h11, 8'h84, 1'b0, 1'b0);
        exp_rd("t7-rd5", 10, 8'h12, 8'h85, 1'b0, 1'b1);
        exp_wr("t7-wr0", 7,  8'h13);
        exp_wr("t7-wr1", 13, 8'h14);
        exp_done("t7-done", 14);
        exp_empty("t7");
        chk_result("t7-result", 8'h13, 8'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
